// File: rtl/obi_pkg.sv
// ----------------------------------------------------------------------------
// obi_pkg
// Shared definitions for the OBI interconnect blocks.
//   OBI_ERR_RDATA : default read data returned for accesses nobody decodes
//   obi_be_w()    : byte-enable width for a given data width
//   obi_clog2()   : ceiling log2, usable in parameter/localparam expressions
// ----------------------------------------------------------------------------
package obi_pkg;

    localparam logic [31:0] OBI_ERR_RDATA = 32'hDEADBEEF;

    function automatic int obi_be_w(input int data_w);
        return data_w / 8;
    endfunction

    // Bounded loop so it stays a legal constant function; values above 2^31
    // are never used as counter limits.
    function automatic int obi_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/obi_err_slave.sv
// ----------------------------------------------------------------------------
// obi_err_slave
// Responder for requests that match no slave address window. It always
// grants, and answers every accepted request exactly one cycle later with
// ERR_RDATA. Back-to-back requests get back-to-back responses.
//
// Ports
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset
//   req_i    in   accepted unmapped request (already qualified with grant)
//   gnt_o    out  constant 1
//   rvalid_o out  registered response valid
//   rdata_o  out  ERR_RDATA
//   err_o    out  error flag, equal to rvalid_o
//                 (present only when OBI_DEMUX_ERR_EN is defined)
// ----------------------------------------------------------------------------
module obi_err_slave
    import obi_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] ERR_RDATA = OBI_ERR_RDATA
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    output logic              rvalid_o,
`ifdef OBI_DEMUX_ERR_EN
    output logic              err_o,
`endif
    output logic [DATA_W-1:0] rdata_o
);

    logic rvalid_d;
    logic rvalid_q;

    always_comb begin
        rvalid_d = req_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    assign gnt_o    = 1'b1;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = ERR_RDATA;
`ifdef OBI_DEMUX_ERR_EN
    assign err_o    = rvalid_q;
`endif

endmodule

// File: rtl/obi_demux_1_to_n.sv
// ----------------------------------------------------------------------------
// obi_demux_1_to_n
// One OBI master to NUM_PORTS OBI slaves. The address is decoded against
// per-port inclusive [BASE, END] windows (lowest index wins on overlap);
// anything unmapped goes to an internal error slave. Up to MAX_OUTSTANDING
// transactions may be in flight, all to the same target, so responses come
// back strictly in order without any reorder buffer.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   ctrl_*                    master side (req/gnt, addr/we/be/wdata, rvalid/rdata)
//   port_req_o / port_gnt_i   per-slave handshake
//   port_addr/we/be/wdata_o   master request broadcast to every slave
//   port_rvalid_i/rdata_i     per-slave responses
//   illegal_access_o          pulse when an unmapped request is granted
//
// Configuration
//   OBI_DEMUX_ERR_EN : adds port_err_i / ctrl_err_o. The error flag follows
//                      the response mux and is forced high for error-slave
//                      responses.
// ----------------------------------------------------------------------------
module obi_demux_1_to_n
    import obi_pkg::*;
#(
    parameter int                          NUM_PORTS       = 4,
    parameter int                          ADDR_W          = 32,
    parameter int                          DATA_W          = 32,
    parameter int                          MAX_OUTSTANDING = 4,
    parameter logic [NUM_PORTS*ADDR_W-1:0] BASE_ADDRS      = {4{32'h0}},
    parameter logic [NUM_PORTS*ADDR_W-1:0] END_ADDRS       = {4{32'hF}},
    parameter logic [DATA_W-1:0]           ERR_RDATA       = OBI_ERR_RDATA
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    ctrl_req_i,
    output logic                                    ctrl_gnt_o,
    input  logic [ADDR_W-1:0]                       ctrl_addr_i,
    input  logic                                    ctrl_we_i,
    input  logic [obi_be_w(DATA_W)-1:0]             ctrl_be_i,
    input  logic [DATA_W-1:0]                       ctrl_wdata_i,
    output logic                                    ctrl_rvalid_o,
    output logic [DATA_W-1:0]                       ctrl_rdata_o,
    output logic [NUM_PORTS-1:0]                    port_req_o,
    input  logic [NUM_PORTS-1:0]                    port_gnt_i,
    output logic [NUM_PORTS*ADDR_W-1:0]             port_addr_o,
    output logic [NUM_PORTS-1:0]                    port_we_o,
    output logic [NUM_PORTS*obi_be_w(DATA_W)-1:0]   port_be_o,
    output logic [NUM_PORTS*DATA_W-1:0]             port_wdata_o,
    input  logic [NUM_PORTS-1:0]                    port_rvalid_i,
    input  logic [NUM_PORTS*DATA_W-1:0]             port_rdata_i,
`ifdef OBI_DEMUX_ERR_EN
    input  logic [NUM_PORTS-1:0]                    port_err_i,
    output logic                                    ctrl_err_o,
`endif
    output logic                                    illegal_access_o
);

    localparam int         CNT_W   = obi_clog2(MAX_OUTSTANDING + 1);
    localparam logic [3:0] ERR_SEL = 4'(NUM_PORTS);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt_d,     cnt_q;
    logic [3:0]       cur_sel_d, cur_sel_q;
    logic [3:0]       sel;
    logic             cnt_zero;
    logic             issue_ok;
    logic             target_gnt;
    logic             accept;
    logic             rsp;
    logic             src_rvalid;
    logic [DATA_W-1:0] src_rdata;

    logic              err_req;
    logic              err_gnt;
    logic              err_rvalid;
    logic [DATA_W-1:0] err_rdata;
`ifdef OBI_DEMUX_ERR_EN
    logic              err_err;
    logic              src_err;
`endif

    // Window checks use an extra borrow bit instead of relational operators
    // so a window starting at address 0 needs no special case.
    always_comb begin
        logic [ADDR_W:0] above_base;
        logic [ADDR_W:0] below_end;
        sel = ERR_SEL;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            above_base = {1'b0, ctrl_addr_i} - {1'b0, BASE_ADDRS[i*ADDR_W +: ADDR_W]};
            below_end  = {1'b0, END_ADDRS[i*ADDR_W +: ADDR_W]} - {1'b0, ctrl_addr_i};
            if (!above_base[ADDR_W] && !below_end[ADDR_W]) begin
                sel = 4'(i);
            end
        end
    end

    // Issue only to the target already in flight (keeps responses ordered),
    // or to anyone once everything has drained. A response arriving this
    // cycle does not count as drained yet.
    always_comb begin
        cnt_zero   = (cnt_q == '0);
        issue_ok   = cnt_zero || ((sel == cur_sel_q) && (cnt_q < MAX_CNT));
        target_gnt = err_gnt;
        port_req_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel == 4'(i)) begin
                target_gnt    = port_gnt_i[i];
                port_req_o[i] = ctrl_req_i && issue_ok;
            end
        end
        ctrl_gnt_o       = issue_ok && target_gnt;
        accept           = ctrl_req_i && ctrl_gnt_o;
        err_req          = accept && (sel == ERR_SEL);
        illegal_access_o = err_req;
    end

    // Responses are taken only from the current target; rvalid on any other
    // port is ignored.
    always_comb begin
        src_rvalid = err_rvalid;
        src_rdata  = err_rdata;
`ifdef OBI_DEMUX_ERR_EN
        src_err    = err_err;
`endif
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (cur_sel_q == 4'(i)) begin
                src_rvalid = port_rvalid_i[i];
                src_rdata  = port_rdata_i[i*DATA_W +: DATA_W];
`ifdef OBI_DEMUX_ERR_EN
                src_err    = port_err_i[i];
`endif
            end
        end
        rsp           = !cnt_zero && src_rvalid;
        ctrl_rvalid_o = rsp;
        ctrl_rdata_o  = cnt_zero ? ERR_RDATA : src_rdata;
`ifdef OBI_DEMUX_ERR_EN
        ctrl_err_o    = rsp && src_err;
`endif
    end

    always_comb begin
        cnt_d     = cnt_q;
        cur_sel_d = cur_sel_q;
        if (accept && !rsp) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!accept && rsp) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (accept) begin
            cur_sel_d = sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            cur_sel_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            cur_sel_q <= cur_sel_d;
        end
    end

    assign port_addr_o  = {NUM_PORTS{ctrl_addr_i}};
    assign port_we_o    = {NUM_PORTS{ctrl_we_i}};
    assign port_be_o    = {NUM_PORTS{ctrl_be_i}};
    assign port_wdata_o = {NUM_PORTS{ctrl_wdata_i}};

    obi_err_slave #(
        .DATA_W    (DATA_W),
        .ERR_RDATA (ERR_RDATA)
    ) u_err_slave (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (err_req),
        .gnt_o    (err_gnt),
        .rvalid_o (err_rvalid),
`ifdef OBI_DEMUX_ERR_EN
        .err_o    (err_err),
`endif
        .rdata_o  (err_rdata)
    );

endmodule

// File: tb/tb_obi_demux_1_to_n.sv
// ----------------------------------------------------------------------------
// tb_obi_demux_1_to_n
// Directed scenarios plus a randomized run against a queue-based model of
// in-flight transactions. Two instances: the main one with up to 4
// outstanding transactions, and a second one limited to 2 for the
// back-pressure scenario.
// ----------------------------------------------------------------------------
module tb_obi_demux_1_to_n;

    localparam int NP   = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int MAXO = 4;
    localparam logic [NP*AW-1:0] BASES = {32'h0000_1800, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    localparam logic [NP*AW-1:0] ENDS  = {32'h0000_3FFF, 32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_0FFF};
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    typedef struct {
        int          src;
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    int checks   = 0;
    int failures = 0;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              ctrl_req_i;
    logic              ctrl_gnt_o;
    logic [AW-1:0]     ctrl_addr_i;
    logic              ctrl_we_i;
    logic [BW-1:0]     ctrl_be_i;
    logic [DW-1:0]     ctrl_wdata_i;
    logic              ctrl_rvalid_o;
    logic [DW-1:0]     ctrl_rdata_o;
    logic [NP-1:0]     port_req_o;
    logic [NP-1:0]     port_gnt_i;
    logic [NP*AW-1:0]  port_addr_o;
    logic [NP-1:0]     port_we_o;
    logic [NP*BW-1:0]  port_be_o;
    logic [NP*DW-1:0]  port_wdata_o;
    logic [NP-1:0]     port_rvalid_i;
    logic [NP*DW-1:0]  port_rdata_i;
    logic              illegal_access_o;

    logic              b_req;
    logic              b_gnt;
    logic [AW-1:0]     b_addr;
    logic              b_rvalid;
    logic [DW-1:0]     b_rdata;
    logic [NP-1:0]     b_port_req;
    logic [NP-1:0]     b_port_gnt;
    logic [NP*AW-1:0]  b_port_addr;
    logic [NP-1:0]     b_port_we;
    logic [NP*BW-1:0]  b_port_be;
    logic [NP*DW-1:0]  b_port_wdata;
    logic [NP-1:0]     b_port_rvalid;
    logic [NP*DW-1:0]  b_port_rdata;
    logic              b_illegal;

`ifdef OBI_DEMUX_ERR_EN
    logic [NP-1:0]     port_err_i;
    logic              ctrl_err_o;
    logic [NP-1:0]     b_port_err;
    logic              b_err;
`endif

    always #5 clk_i = ~clk_i;

    obi_demux_1_to_n #(
        .NUM_PORTS       (NP),
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (MAXO),
        .BASE_ADDRS      (BASES),
        .END_ADDRS       (ENDS),
        .ERR_RDATA       (ERR_DATA)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .ctrl_req_i       (ctrl_req_i),
        .ctrl_gnt_o       (ctrl_gnt_o),
        .ctrl_addr_i      (ctrl_addr_i),
        .ctrl_we_i        (ctrl_we_i),
        .ctrl_be_i        (ctrl_be_i),
        .ctrl_wdata_i     (ctrl_wdata_i),
        .ctrl_rvalid_o    (ctrl_rvalid_o),
        .ctrl_rdata_o     (ctrl_rdata_o),
        .port_req_o       (port_req_o),
        .port_gnt_i       (port_gnt_i),
        .port_addr_o      (port_addr_o),
        .port_we_o        (port_we_o),
        .port_be_o        (port_be_o),
        .port_wdata_o     (port_wdata_o),
        .port_rvalid_i    (port_rvalid_i),
        .port_rdata_i     (port_rdata_i),
`ifdef OBI_DEMUX_ERR_EN
        .port_err_i       (port_err_i),
        .ctrl_err_o       (ctrl_err_o),
`endif
        .illegal_access_o (illegal_access_o)
    );

    obi_demux_1_to_n #(
        .NUM_PORTS       (NP),
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (2),
        .BASE_ADDRS      (BASES),
        .END_ADDRS       (ENDS),
        .ERR_RDATA       (ERR_DATA)
    ) dut_max2 (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .ctrl_req_i       (b_req),
        .ctrl_gnt_o       (b_gnt),
        .ctrl_addr_i      (b_addr),
        .ctrl_we_i        (ctrl_we_i),
        .ctrl_be_i        (ctrl_be_i),
        .ctrl_wdata_i     (ctrl_wdata_i),
        .ctrl_rvalid_o    (b_rvalid),
        .ctrl_rdata_o     (b_rdata),
        .port_req_o       (b_port_req),
        .port_gnt_i       (b_port_gnt),
        .port_addr_o      (b_port_addr),
        .port_we_o        (b_port_we),
        .port_be_o        (b_port_be),
        .port_wdata_o     (b_port_wdata),
        .port_rvalid_i    (b_port_rvalid),
        .port_rdata_i     (b_port_rdata),
`ifdef OBI_DEMUX_ERR_EN
        .port_err_i       (b_port_err),
        .ctrl_err_o       (b_err),
`endif
        .illegal_access_o (b_illegal)
    );

    // Reference address decode: lowest-index inclusive window, else NP.
    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NP; i++) begin
            if (a >= BASES[i*AW +: AW] && a <= ENDS[i*AW +: AW]) begin
                return i;
            end
        end
        return NP;
    endfunction

    task automatic do_reset();
        rst_ni        = 1'b0;
        ctrl_req_i    = 1'b0;
        ctrl_addr_i   = '0;
        ctrl_we_i     = 1'b0;
        ctrl_be_i     = '0;
        ctrl_wdata_i  = '0;
        port_gnt_i    = '0;
        port_rvalid_i = '0;
        port_rdata_i  = '0;
        b_req         = 1'b0;
        b_addr        = '0;
        b_port_gnt    = '0;
        b_port_rvalid = '0;
        b_port_rdata  = '0;
`ifdef OBI_DEMUX_ERR_EN
        port_err_i    = '0;
        b_port_err    = '0;
`endif
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_ni      = 1'b0;
        ctrl_req_i  = 1'b1;
        ctrl_addr_i = 32'h0000_1000;
        port_gnt_i  = 4'hF;
        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if (ctrl_rvalid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_rvalid: got %b expected 0", ctrl_rvalid_o);
        end
        checks++;
        if (ctrl_rdata_o !== ERR_DATA) begin
            failures++;
            $display("[TB] FAIL rst_rdata: got %h expected %h", ctrl_rdata_o, ERR_DATA);
        end
`ifdef OBI_DEMUX_ERR_EN
        checks++;
        if (ctrl_err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_err: got %b expected 0", ctrl_err_o);
        end
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checks++;
        if (ctrl_gnt_o !== 1'b1 || port_req_o !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL rst_first_gnt: got gnt=%b req=%b expected gnt=1 req=0010", ctrl_gnt_o, port_req_o);
        end
        @(negedge clk_i);
        ctrl_req_i    = 1'b0;
        port_rvalid_i = 4'b0010;
        port_rdata_i  = '0;
        port_rdata_i[1*DW +: DW] = 32'h1234_5678;
        #1;
        checks++;
        if (ctrl_rvalid_o !== 1'b1 || ctrl_rdata_o !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL rst_first_rsp: got rvalid=%b rdata=%h expected 1 12345678", ctrl_rvalid_o, ctrl_rdata_o);
        end
        @(negedge clk_i);
        port_rvalid_i = '0;
    endtask

    task automatic test_back_to_back();
        logic exp_rv;
        do_reset();
        port_gnt_i = 4'hF;
        for (int c = 0; c < 8; c++) begin
            ctrl_req_i    = (c < 4) || (c == 7);
            ctrl_addr_i   = (c == 7) ? 32'h0000_2000 : 32'h0000_1000 + 32'(4 * c);
            exp_rv        = (c >= 3) && (c <= 6);
            port_rvalid_i = exp_rv ? 4'b0010 : 4'b0000;
            port_rdata_i  = {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hA000_0000 + 32'(c), 32'hB0B0_B0B0};
            #1;
            if (ctrl_req_i) begin
                checks++;
                if (ctrl_gnt_o !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL b2b_gnt c=%0d: got %b expected 1", c, ctrl_gnt_o);
                end
            end
            checks++;
            if (ctrl_rvalid_o !== exp_rv) begin
                failures++;
                $display("[TB] FAIL b2b_rvalid c=%0d: got %b expected %b", c, ctrl_rvalid_o, exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (ctrl_rdata_o !== 32'hA000_0000 + 32'(c)) begin
                    failures++;
                    $display("[TB] FAIL b2b_rdata c=%0d: got %h expected %h", c, ctrl_rdata_o, 32'hA000_0000 + 32'(c));
                end
            end
            if (c == 7) begin
                checks++;
                if (ctrl_rdata_o !== ERR_DATA || port_req_o !== 4'b0100) begin
                    failures++;
                    $display("[TB] FAIL b2b_drained: got rdata=%h req=%b expected %h 0100", ctrl_rdata_o, port_req_o, ERR_DATA);
                end
            end
            @(negedge clk_i);
        end
        ctrl_req_i    = 1'b0;
        port_rvalid_i = '0;
    endtask

    task automatic test_max_outstanding();
        logic       exp_gnt;
        logic       exp_rv;
        do_reset();
        b_port_gnt = 4'hF;
        b_addr     = 32'h0000_1100;
        for (int c = 0; c < 7; c++) begin
            b_req         = (c <= 5);
            exp_rv        = (c == 4) || (c == 6);
            b_port_rvalid = exp_rv ? 4'b0010 : 4'b0000;
            b_port_rdata  = '0;
            b_port_rdata[1*DW +: DW] = 32'hC000_0000 + 32'(c);
            exp_gnt       = !((c >= 2) && (c <= 4));
            #1;
            if (b_req) begin
                checks++;
                if (b_gnt !== exp_gnt || b_port_req !== (exp_gnt ? 4'b0010 : 4'b0000)) begin
                    failures++;
                    $display("[TB] FAIL max_gnt c=%0d: got gnt=%b req=%b expected gnt=%b", c, b_gnt, b_port_req, exp_gnt);
                end
            end
            checks++;
            if (b_rvalid !== exp_rv || (exp_rv && b_rdata !== 32'hC000_0000 + 32'(c))) begin
                failures++;
                $display("[TB] FAIL max_rsp c=%0d: got rvalid=%b rdata=%h expected rvalid=%b", c, b_rvalid, b_rdata, exp_rv);
            end
            if (c == 0) begin
                checks++;
                if (b_port_addr !== {NP{b_addr}} || b_port_we !== {NP{ctrl_we_i}} ||
                    b_port_be !== {NP{ctrl_be_i}} || b_port_wdata !== {NP{ctrl_wdata_i}} || b_illegal !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL max_bcast: got addr=%h illegal=%b expected addr=%h illegal=0", b_port_addr, b_illegal, {NP{b_addr}});
                end
            end
`ifdef OBI_DEMUX_ERR_EN
            checks++;
            if (b_err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL max_err c=%0d: got %b expected 0", c, b_err);
            end
`endif
            @(negedge clk_i);
        end
        b_req         = 1'b0;
        b_port_rvalid = '0;
    endtask

    task automatic test_switch_target();
        logic [3:0] exp_req;
        logic       exp_gnt;
        logic       exp_rv;
        logic [31:0] exp_data;
        do_reset();
        port_gnt_i = 4'hF;
        for (int c = 0; c < 7; c++) begin
            ctrl_req_i    = (c <= 4);
            ctrl_addr_i   = (c == 0) ? 32'h0000_0010 : 32'h0000_2000;
            port_rvalid_i = (c == 1) ? 4'b0100 : (c == 3) ? 4'b0001 : (c == 5) ? 4'b0101 : 4'b0000;
            port_rdata_i  = {32'h3333_3333, 32'hE000_0000 + 32'(c), 32'h1111_1111, 32'hD000_0000 + 32'(c)};
            exp_gnt       = (c == 0) || (c == 4);
            exp_req       = (c == 0) ? 4'b0001 : (c == 4) ? 4'b0100 : 4'b0000;
            exp_rv        = (c == 3) || (c == 5);
            exp_data      = (c == 3) ? 32'hD000_0003 : (c == 5) ? 32'hE000_0005 : ERR_DATA;
            #1;
            if (ctrl_req_i) begin
                checks++;
                if (ctrl_gnt_o !== exp_gnt || port_req_o !== exp_req) begin
                    failures++;
                    $display("[TB] FAIL switch_issue c=%0d: got gnt=%b req=%b expected gnt=%b req=%b", c, ctrl_gnt_o, port_req_o, exp_gnt, exp_req);
                end
            end
            checks++;
            if (ctrl_rvalid_o !== exp_rv) begin
                failures++;
                $display("[TB] FAIL switch_rvalid c=%0d: got %b expected %b", c, ctrl_rvalid_o, exp_rv);
            end
            if (exp_rv || c == 6) begin
                checks++;
                if (ctrl_rdata_o !== exp_data) begin
                    failures++;
                    $display("[TB] FAIL switch_rdata c=%0d: got %h expected %h", c, ctrl_rdata_o, exp_data);
                end
            end
            @(negedge clk_i);
        end
        port_rvalid_i = '0;
    endtask

    task automatic test_unmapped();
        logic exp_acc;
        logic exp_rv;
        do_reset();
        port_gnt_i = 4'h0;
        for (int c = 0; c < 4; c++) begin
            ctrl_req_i    = (c <= 1);
            ctrl_addr_i   = 32'hFFFF_0000 + 32'(4 * c);
            port_rvalid_i = (c >= 2) ? 4'b0001 : 4'b0000;
            port_rdata_i  = {NP{32'h5555_5555}};
            exp_acc       = (c <= 1);
            exp_rv        = (c == 1) || (c == 2);
            #1;
            if (ctrl_req_i) begin
                checks++;
                if (ctrl_gnt_o !== 1'b1 || port_req_o !== 4'b0000) begin
                    failures++;
                    $display("[TB] FAIL unmapped_gnt c=%0d: got gnt=%b req=%b expected gnt=1 req=0000", c, ctrl_gnt_o, port_req_o);
                end
            end
            checks++;
            if (illegal_access_o !== exp_acc) begin
                failures++;
                $display("[TB] FAIL unmapped_illegal c=%0d: got %b expected %b", c, illegal_access_o, exp_acc);
            end
            checks++;
            if (ctrl_rvalid_o !== exp_rv || ctrl_rdata_o !== ERR_DATA) begin
                failures++;
                $display("[TB] FAIL unmapped_rsp c=%0d: got rvalid=%b rdata=%h expected rvalid=%b rdata=%h", c, ctrl_rvalid_o, ctrl_rdata_o, exp_rv, ERR_DATA);
            end
`ifdef OBI_DEMUX_ERR_EN
            checks++;
            if (ctrl_err_o !== exp_rv) begin
                failures++;
                $display("[TB] FAIL unmapped_err c=%0d: got %b expected %b", c, ctrl_err_o, exp_rv);
            end
`endif
            @(negedge clk_i);
        end
        port_rvalid_i = '0;
    endtask

    task automatic test_overlap();
        logic [31:0] addrs   [6];
        logic [3:0]  exp_req [6];
        addrs   = '{32'h0000_1900, 32'h0000_1FFF, 32'h0000_3100, 32'h0000_2FFF, 32'h0000_0FFF, 32'h0000_4000};
        exp_req = '{4'b0010, 4'b0010, 4'b1000, 4'b0100, 4'b0001, 4'b0000};
        do_reset();
        port_gnt_i = 4'h0;
        for (int k = 0; k < 6; k++) begin
            ctrl_req_i   = 1'b1;
            ctrl_addr_i  = addrs[k];
            ctrl_we_i    = k[0];
            ctrl_be_i    = 4'(k + 3);
            ctrl_wdata_i = 32'h600D_0000 + 32'(k);
            #1;
            checks++;
            if (port_req_o !== exp_req[k]) begin
                failures++;
                $display("[TB] FAIL overlap_req addr=%h: got %b expected %b", addrs[k], port_req_o, exp_req[k]);
            end
            checks++;
            if (port_addr_o !== {NP{addrs[k]}} || port_we_o !== {NP{k[0]}} ||
                port_be_o !== {NP{4'(k + 3)}} || port_wdata_o !== {NP{32'h600D_0000 + 32'(k)}}) begin
                failures++;
                $display("[TB] FAIL overlap_bcast addr=%h: got addr=%h we=%b expected addr=%h", addrs[k], port_addr_o, port_we_o, {NP{addrs[k]}});
            end
            @(negedge clk_i);
        end
        ctrl_req_i = 1'b0;
    endtask

    task automatic test_random();
        rsp_t        pend[$];
        rsp_t        entry;
        int          target;
        int          sel;
        int          due;
        logic        holding;
        logic        ok;
        logic        gnt_exp;
        logic        resp_now;
        logic [3:0]  preq_exp;
        logic [31:0] addr_rand;
        do_reset();
        target  = 0;
        holding = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!holding) begin
                ctrl_req_i = ($urandom_range(0, 3) != 0);
                addr_rand  = $urandom;
                case ($urandom_range(0, 4))
                    0:       ctrl_addr_i = {20'h00000, addr_rand[11:0]};
                    1:       ctrl_addr_i = {20'h00001, addr_rand[11:0]};
                    2:       ctrl_addr_i = {20'h00002, addr_rand[11:0]};
                    3:       ctrl_addr_i = {20'h00003, addr_rand[11:0]};
                    default: ctrl_addr_i = {16'hFFFF, addr_rand[15:0]};
                endcase
                ctrl_we_i    = 1'($urandom);
                ctrl_be_i    = 4'($urandom);
                ctrl_wdata_i = $urandom;
            end
            port_gnt_i    = 4'($urandom);
            port_rdata_i  = {$urandom, $urandom, $urandom, $urandom};
            port_rvalid_i = '0;
            for (int p = 0; p < NP; p++) begin
                if (p != target && $urandom_range(0, 3) == 0) begin
                    port_rvalid_i[p] = 1'b1;
                end
            end
            resp_now = (pend.size() > 0) && (pend[0].due == cyc);
`ifdef OBI_DEMUX_ERR_EN
            port_err_i = 4'($urandom);
`endif
            if (resp_now && pend[0].src < NP) begin
                port_rvalid_i[pend[0].src]            = 1'b1;
                port_rdata_i[pend[0].src*DW +: DW]    = pend[0].data;
`ifdef OBI_DEMUX_ERR_EN
                port_err_i[pend[0].src]               = pend[0].err;
`endif
            end
            sel = ref_decode(ctrl_addr_i);
            ok  = (pend.size() == 0) || (sel == target && pend.size() < MAXO);
            if (sel == NP) begin
                gnt_exp = ok;
            end else begin
                gnt_exp = ok && port_gnt_i[sel];
            end
            preq_exp = '0;
            if (ctrl_req_i && ok && sel < NP) begin
                preq_exp[sel] = 1'b1;
            end
            #1;
            checks++;
            if (ctrl_gnt_o !== gnt_exp || port_req_o !== preq_exp) begin
                failures++;
                $display("[TB] FAIL rand_issue cyc=%0d: got gnt=%b req=%b expected gnt=%b req=%b", cyc, ctrl_gnt_o, port_req_o, gnt_exp, preq_exp);
            end
            checks++;
            if (illegal_access_o !== (ctrl_req_i && gnt_exp && sel == NP)) begin
                failures++;
                $display("[TB] FAIL rand_illegal cyc=%0d: got %b expected %b", cyc, illegal_access_o, ctrl_req_i && gnt_exp && sel == NP);
            end
            checks++;
            if (ctrl_rvalid_o !== resp_now) begin
                failures++;
                $display("[TB] FAIL rand_rvalid cyc=%0d: got %b expected %b", cyc, ctrl_rvalid_o, resp_now);
            end
            if (resp_now) begin
                checks++;
                if (ctrl_rdata_o !== pend[0].data) begin
                    failures++;
                    $display("[TB] FAIL rand_rdata cyc=%0d: got %h expected %h", cyc, ctrl_rdata_o, pend[0].data);
                end
`ifdef OBI_DEMUX_ERR_EN
                checks++;
                if (ctrl_err_o !== pend[0].err) begin
                    failures++;
                    $display("[TB] FAIL rand_err cyc=%0d: got %b expected %b", cyc, ctrl_err_o, pend[0].err);
                end
`endif
            end else if (pend.size() == 0) begin
                checks++;
                if (ctrl_rdata_o !== ERR_DATA) begin
                    failures++;
                    $display("[TB] FAIL rand_idle_rdata cyc=%0d: got %h expected %h", cyc, ctrl_rdata_o, ERR_DATA);
                end
            end
            checks++;
            if (port_addr_o !== {NP{ctrl_addr_i}} || port_wdata_o !== {NP{ctrl_wdata_i}}) begin
                failures++;
                $display("[TB] FAIL rand_bcast cyc=%0d: got addr=%h expected %h", cyc, port_addr_o, {NP{ctrl_addr_i}});
            end
            @(negedge clk_i);
            if (resp_now) begin
                void'(pend.pop_front());
            end
            if (ctrl_req_i && gnt_exp) begin
                target = sel;
                if (sel == NP) begin
                    entry.src  = NP;
                    entry.due  = cyc + 1;
                    entry.data = ERR_DATA;
                    entry.err  = 1'b1;
                end else begin
                    due = cyc + $urandom_range(1, 4);
                    if (pend.size() > 0 && due <= pend[$].due) begin
                        due = pend[$].due + 1;
                    end
                    entry.src  = sel;
                    entry.due  = due;
                    entry.data = $urandom;
                    entry.err  = 1'($urandom);
                end
                pend.push_back(entry);
            end
            holding = ctrl_req_i && !gnt_exp;
        end
        ctrl_req_i    = 1'b0;
        port_rvalid_i = '0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_max_outstanding();
        test_switch_target();
        test_unmapped();
        test_overlap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
